seven_seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a multi-digit common-segment 7-segment display. One shared bcd_to_sevenseg decoder serves all digits.
- Each dwell period the block selects one digit, drives that digit's BCD nibble to the decoder and asserts its digit-select line.
- Between digits it inserts optional anti-ghosting blank gaps.
- New display values are applied only at frame boundaries, so no frame ever shows a mix of old and new values.
- Sits between the value-producing logic and the decoder/display pins.

---
 rtl/seven_seg_pkg.sv | 27 ++
 rtl/seven_seg_scan_ctrl_timer.sv | 37 +++
 rtl/seven_seg_scan_ctrl.sv | 156 +++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
package seven_seg_pkg;

  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned MAX_DIGITS = 8;
  localparam logic [NIBBLE_W-1:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } scan_state_e;

  // Bit k set when nibble k and every nibble above it are zero; digit 0 is never masked.
  function automatic logic [MAX_DIGITS-1:0] lead_zero_mask(
    input logic [MAX_DIGITS*NIBBLE_W-1:0] v
  );
    logic zero_above;
    lead_zero_mask = '0;
    zero_above     = 1'b1;
    for (int k = MAX_DIGITS - 1; k >= 1; k--) begin
      zero_above        = zero_above && (v[k*NIBBLE_W +: NIBBLE_W] == '0);
      lead_zero_mask[k] = zero_above;
    end
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_timer.sv
// Loadable down-counter with terminal-count flag, shared by the dwell and gap periods.
module scan_dwell_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc_c,
  output logic [W-1:0] count_next_c
);

  logic [W-1:0] count;

  always_comb begin
    count_next_c = count;
    if (clear) begin
      count_next_c = '0;
    end else if (load) begin
      count_next_c = load_val;
    end else if (count != '0) begin
      count_next_c = count - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_next_c;
    end
  end

  assign tc_c = (count == '0);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-synchronous value updates.
// Optional leading-zero blanking: define SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DWELL_CYCLES = 50000,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [NUM_DIGITS*NIBBLE_W-1:0] digits_in,
  input  logic                           load,
  output logic [NIBBLE_W-1:0]            bcd_out,
  output logic [NUM_DIGITS-1:0]          digit_sel,
  output logic                           frame_done
);

  localparam int unsigned DATA_W  = NUM_DIGITS * NIBBLE_W;
  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
  localparam int unsigned TMR_MAX = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [TMR_W-1:0] DWELL_LOAD = TMR_W'(DWELL_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  // frame_done marks the last cycle before the wrap: end of the last gap, or of the last dwell when gaps are off.
  localparam scan_state_e FD_STATE = (GAP_CYCLES > 0) ? GAP : SHOW;

  scan_state_e       state, state_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [DATA_W-1:0] staging, staging_n;
  logic [DATA_W-1:0] shadow, shadow_n;
  logic              pending, pending_n;
  logic              boundary, adv;
  logic              tmr_clear, tmr_load, tmr_tc;
  logic [TMR_W-1:0]  tmr_val, tmr_next;
  logic [NIBBLE_W-1:0]   bcd_n;
  logic [NUM_DIGITS-1:0] sel_n;
  logic                  fd_n;

  scan_dwell_timer #(.W(TMR_W)) u_timer (
    .clk          (clk),
    .rst          (rst),
    .clear        (tmr_clear),
    .load         (tmr_load),
    .load_val     (tmr_val),
    .tc_c         (tmr_tc),
    .count_next_c (tmr_next)
  );

  // State, staging/shadow registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      staging    <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      bcd_out    <= BCD_BLANK;
      digit_sel  <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      staging    <= staging_n;
      shadow     <= shadow_n;
      pending    <= pending_n;
      bcd_out    <= bcd_n;
      digit_sel  <= sel_n;
      frame_done <= fd_n;
    end
  end

  // Next-state, timer control and frame-boundary value transfer.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    tmr_clear = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = DWELL_LOAD;
    boundary  = 1'b0;
    adv       = 1'b0;
    if (!en) begin
      state_n   = IDLE;
      idx_n     = '0;
      tmr_clear = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state_n  = SHOW;
          idx_n    = '0;
          tmr_load = 1'b1;
          boundary = 1'b1;
        end
        SHOW: begin
          if (tmr_tc) begin
            if (GAP_CYCLES > 0) begin
              state_n  = GAP;
              tmr_load = 1'b1;
              tmr_val  = GAP_LOAD;
            end else begin
              adv = 1'b1;
            end
          end
        end
        GAP: begin
          if (tmr_tc) adv = 1'b1;
        end
        default: begin
          state_n   = IDLE;
          idx_n     = '0;
          tmr_clear = 1'b1;
        end
      endcase
    end
    if (adv) begin
      state_n  = SHOW;
      tmr_load = 1'b1;
      tmr_val  = DWELL_LOAD;
      if (idx == LAST_IDX) begin
        idx_n    = '0;
        boundary = 1'b1;
      end else begin
        idx_n = idx + IDX_W'(1);
      end
    end
    // Shadow takes the old staging; a coincident load refills staging and keeps pending set.
    shadow_n  = (boundary && pending) ? staging : shadow;
    pending_n = load ? 1'b1 : (boundary ? 1'b0 : pending);
    staging_n = load ? digits_in : staging;
  end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic [MAX_DIGITS-1:0] lz_mask;
  assign lz_mask = lead_zero_mask((MAX_DIGITS*NIBBLE_W)'(shadow_n));
`endif

  // Output values for the cycle being entered, so select and nibble switch together.
  always_comb begin
    sel_n = '0;
    bcd_n = BCD_BLANK;
    fd_n  = 1'b0;
    if (state_n == SHOW) begin
      sel_n = NUM_DIGITS'(1) << idx_n;
      bcd_n = shadow_n[idx_n*NIBBLE_W +: NIBBLE_W];
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
      if (lz_mask[idx_n]) bcd_n = BCD_BLANK;
`endif
    end
    if ((state_n == FD_STATE) && (idx_n == LAST_IDX) && (tmr_next == '0)) begin
      fd_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: frame-position model plus directed literal checks.
module tb_seven_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int DW = 4;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] din = 16'h0;
  logic [3:0]  sel_a, bcd_a, sel_b, bcd_b;
  logic        fd_a, fd_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(.NUM_DIGITS(4), .DWELL_CYCLES(4), .GAP_CYCLES(1)) u_a (
    .clk(clk), .rst(rst), .en(en), .digits_in(din), .load(load),
    .bcd_out(bcd_a), .digit_sel(sel_a), .frame_done(fd_a)
  );

  seven_seg_scan_ctrl #(.NUM_DIGITS(4), .DWELL_CYCLES(4), .GAP_CYCLES(0)) u_b (
    .clk(clk), .rst(rst), .en(en), .digits_in(din), .load(load),
    .bcd_out(bcd_b), .digit_sel(sel_b), .frame_done(fd_b)
  );

  // Model: position within the frame decides digit/gap; values switch only at position 0.
  bit          m_act  [2];
  int          m_p    [2];
  logic [15:0] m_stg  [2];
  logic [15:0] m_shd  [2];
  bit          m_pend [2];
  logic [3:0]  e_sel  [2];
  logic [3:0]  e_bcd  [2];
  logic        e_fd   [2];

  always @(posedge clk) begin
    started = 1'b1;
    for (int i = 0; i < 2; i++) begin
      int gap, slot, period, d, off;
      bit bnd;
      logic [15:0] above;
      gap    = (i == 0) ? 1 : 0;
      slot   = DW + gap;
      period = ND * slot;
      bnd    = 1'b0;
      if (rst) begin
        m_act[i] = 1'b0; m_p[i] = 0; m_stg[i] = '0; m_shd[i] = '0; m_pend[i] = 1'b0;
      end else begin
        if (!en) m_act[i] = 1'b0;
        else if (!m_act[i]) begin m_act[i] = 1'b1; m_p[i] = 0; bnd = 1'b1; end
        else begin m_p[i] = (m_p[i] + 1) % period; bnd = (m_p[i] == 0); end
        if (bnd && m_pend[i]) m_shd[i] = m_stg[i];
        if (bnd) m_pend[i] = 1'b0;
        if (load) begin m_stg[i] = din; m_pend[i] = 1'b1; end
      end
      e_sel[i] = 4'h0; e_bcd[i] = 4'hF; e_fd[i] = 1'b0;
      if (m_act[i]) begin
        d   = m_p[i] / slot;
        off = m_p[i] % slot;
        if (off < DW) begin
          e_sel[i] = 4'(1 << d);
          above    = m_shd[i] >> (4 * d);
          e_bcd[i] = above[3:0];
          if (LZ && d >= 1 && above == 16'h0) e_bcd[i] = 4'hF;
        end
        e_fd[i] = (m_p[i] == period - 1);
      end
    end
  end

  task automatic cmp_model();
    logic [8:0] got, want;
    for (int i = 0; i < 2; i++) begin
      got  = (i == 0) ? {sel_a, bcd_a, fd_a} : {sel_b, bcd_b, fd_b};
      want = {e_sel[i], e_bcd[i], e_fd[i]};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL model dut%0d cyc=%0d got sel/bcd/fd=%b/%h/%b want %b/%h/%b",
                 i, cyc, got[8:5], got[4:1], got[0], want[8:5], want[4:1], want[0]);
      end
    end
  endtask

  task automatic lit(input string nm, input logic [8:0] got, input logic [8:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got sel/bcd/fd=%b/%h/%b want %b/%h/%b",
               nm, cyc, got[8:5], got[4:1], got[0], want[8:5], want[4:1], want[0]);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (started) cmp_model();
  endtask

  initial begin
    logic [3:0] lzb;
    lzb = LZ ? 4'hF : 4'h0;
    rst = 1'b1;
    step();
    step();
    lit("reset_a", {sel_a, bcd_a, fd_a}, {4'b0000, 4'hF, 1'b0});
    lit("reset_b", {sel_b, bcd_b, fd_b}, {4'b0000, 4'hF, 1'b0});
    rst = 1'b0;
    step();
    lit("idle_no_en", {sel_a, bcd_a, fd_a}, {4'b0000, 4'hF, 1'b0});
    load = 1'b1; din = 16'h1234;
    step();
    load = 1'b0; en = 1'b1;
    for (int c = 1; c <= 120; c++) begin
      step();
      case (c)
        1:   lit("t1_d0_first", {sel_a, bcd_a, fd_a}, {4'b0001, 4'h4, 1'b0});
        4:   begin
               lit("t1_d0_last", {sel_a, bcd_a, fd_a}, {4'b0001, 4'h4, 1'b0});
               lit("t5_d0_last", {sel_b, bcd_b, fd_b}, {4'b0001, 4'h4, 1'b0});
             end
        5:   begin
               lit("t1_gap0", {sel_a, bcd_a, fd_a}, {4'b0000, 4'hF, 1'b0});
               lit("t5_d1_nogap", {sel_b, bcd_b, fd_b}, {4'b0010, 4'h3, 1'b0});
             end
        6:   lit("t1_d1", {sel_a, bcd_a, fd_a}, {4'b0010, 4'h3, 1'b0});
        16:  begin
               lit("t1_d3_first", {sel_a, bcd_a, fd_a}, {4'b1000, 4'h1, 1'b0});
               lit("t5_fd_last_d3", {sel_b, bcd_b, fd_b}, {4'b1000, 4'h1, 1'b1});
             end
        17:  lit("t5_wrap", {sel_b, bcd_b, fd_b}, {4'b0001, 4'h4, 1'b0});
        19:  lit("t1_d3_last", {sel_a, bcd_a, fd_a}, {4'b1000, 4'h1, 1'b0});
        20:  lit("t1_fd_gap", {sel_a, bcd_a, fd_a}, {4'b0000, 4'hF, 1'b1});
        21:  lit("t1_wrap", {sel_a, bcd_a, fd_a}, {4'b0001, 4'h4, 1'b0});
        27:  begin load = 1'b1; din = 16'h5678; end
        28:  load = 1'b0;
        31:  lit("t2_old_d2", {sel_a, bcd_a, fd_a}, {4'b0100, 4'h2, 1'b0});
        36:  lit("t2_old_d3", {sel_a, bcd_a, fd_a}, {4'b1000, 4'h1, 1'b0});
        41:  lit("t2_new_d0", {sel_a, bcd_a, fd_a}, {4'b0001, 4'h8, 1'b0});
        46:  lit("t2_new_d1", {sel_a, bcd_a, fd_a}, {4'b0010, 4'h7, 1'b0});
        51:  lit("t2_new_d2", {sel_a, bcd_a, fd_a}, {4'b0100, 4'h6, 1'b0});
        52:  en = 1'b0;
        53:  begin
               lit("t3_en_drop", {sel_a, bcd_a, fd_a}, {4'b0000, 4'hF, 1'b0});
               en = 1'b1;
             end
        54:  lit("t3_restart", {sel_a, bcd_a, fd_a}, {4'b0001, 4'h8, 1'b0});
        57:  lit("t3_full_dwell", {sel_a, bcd_a, fd_a}, {4'b0001, 4'h8, 1'b0});
        58:  lit("t3_gap", {sel_a, bcd_a, fd_a}, {4'b0000, 4'hF, 1'b0});
        59:  lit("t3_d1", {sel_a, bcd_a, fd_a}, {4'b0010, 4'h7, 1'b0});
        60:  begin load = 1'b1; din = 16'h0070; end
        61:  load = 1'b0;
        74:  lit("t6_d0_zero", {sel_a, bcd_a, fd_a}, {4'b0001, 4'h0, 1'b0});
        79:  lit("t6_d1_seven", {sel_a, bcd_a, fd_a}, {4'b0010, 4'h7, 1'b0});
        84:  lit("t6_d2_lz", {sel_a, bcd_a, fd_a}, {4'b0100, lzb, 1'b0});
        85:  begin load = 1'b1; din = 16'h0000; end
        86:  load = 1'b0;
        89:  lit("t6_d3_lz", {sel_a, bcd_a, fd_a}, {4'b1000, lzb, 1'b0});
        94:  lit("t6_all0_d0", {sel_a, bcd_a, fd_a}, {4'b0001, 4'h0, 1'b0});
        99:  lit("t6_all0_d1", {sel_a, bcd_a, fd_a}, {4'b0010, lzb, 1'b0});
        112: rst = 1'b1;
        113: begin
               lit("t4_rst_a", {sel_a, bcd_a, fd_a}, {4'b0000, 4'hF, 1'b0});
               lit("t4_rst_b", {sel_b, bcd_b, fd_b}, {4'b0000, 4'hF, 1'b0});
               rst = 1'b0;
             end
        114: lit("t4_cleared", {sel_a, bcd_a, fd_a}, {4'b0001, 4'h0, 1'b0});
        default: ;
      endcase
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
